// File: rtl/prefetch_pkg.sv
// Shared types and helpers for the instruction prefetch buffer.
// Address/word widths come from RISCV_ADDR_WIDTH / RISCV_WORD_WIDTH (default 32).
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

package prefetch_pkg;
   localparam int ADDR_W = `RISCV_ADDR_WIDTH;
   localparam int WORD_W = `RISCV_WORD_WIDTH;
   localparam logic [ADDR_W-1:0] PC_INC = 1;

   typedef struct packed {
      logic [WORD_W-1:0] instr;
      logic [ADDR_W-1:0] pc;
   } fetch_entry_t;

   // Word-addressed PC advance; wraps modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
      return pc + PC_INC;
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// Generic register-based synchronous FIFO with flush; an extra pointer bit
// separates full from empty. Push while full is accepted only alongside a pop.
module sync_fifo #(
   parameter int  DEPTH = 4,
   parameter int  WIDTH = 8,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic [PTR_W:0]   diff;
   logic             do_push;
   logic             do_pop;

   assign diff    = wr_ptr - rd_ptr;
   assign count   = CNT_W'(diff);
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (diff == (PTR_W+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
   end

   // Storage is data only; validity is carried entirely by the pointers.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr[PTR_W-1:0]] <= wdata;
   end
endmodule

// File: rtl/prefetch_buffer.sv
// Prefetch buffer between fetch_stage and decode: credit-throttled requests,
// PC tagging, redirect flush with stale-response discard. Optional PREFETCH_BYPASS_EN.
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

module prefetch_buffer
   import prefetch_pkg::*;
#(
   parameter int  DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   output logic                         fetch_req_o,
   output logic [`RISCV_ADDR_WIDTH-1:0] fetch_target_addr_o,
   output logic                         fetch_target_valid_o,
   input  logic [`RISCV_WORD_WIDTH-1:0] fetch_instr_i,
   input  logic                         fetch_instr_valid_i,
   input  logic                         redirect_i,
   input  logic [`RISCV_ADDR_WIDTH-1:0] redirect_addr_i,
   output logic [`RISCV_WORD_WIDTH-1:0] instr_o,
   output logic [`RISCV_ADDR_WIDTH-1:0] pc_o,
   output logic                         valid_o,
   input  logic                         ready_i
);
   fetch_entry_t      head;
   fetch_entry_t      wentry;
   logic [CNT_W-1:0]  occ;
   logic [CNT_W-1:0]  inflight;
   logic [CNT_W-1:0]  inflight_next;
   logic [CNT_W-1:0]  discard;
   logic [CNT_W:0]    pending;
   logic [ADDR_W-1:0] wr_pc;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;
   logic              accept;
   logic              credit_ok;

   // Requests are gated by reset so nothing is issued while the block is held.
   assign pending              = {1'b0, occ} + {1'b0, inflight};
   assign credit_ok            = (pending < (CNT_W+1)'(DEPTH)) && (discard == '0);
   assign fetch_req_o          = rst_n && (redirect_i || credit_ok);
   assign fetch_target_valid_o = rst_n && redirect_i;
   assign fetch_target_addr_o  = redirect_addr_i;

   assign accept        = fetch_instr_valid_i && (discard == '0) && !redirect_i;
   assign inflight_next = inflight + CNT_W'(fetch_req_o) - CNT_W'(fetch_instr_valid_i);
   assign wentry        = '{instr: fetch_instr_i, pc: wr_pc};

`ifdef PREFETCH_BYPASS_EN
   logic bypass;
   // An empty buffer forwards the arriving response straight to decode.
   assign bypass    = fifo_empty && accept;
   assign valid_o   = !fifo_empty || bypass;
   assign instr_o   = !fifo_empty ? head.instr : (bypass ? fetch_instr_i : '0);
   assign pc_o      = !fifo_empty ? head.pc    : (bypass ? wr_pc : '0);
   assign fifo_push = accept && !(bypass && ready_i) && (!fifo_full || fifo_pop);
`else
   assign valid_o   = !fifo_empty;
   assign instr_o   = fifo_empty ? '0 : head.instr;
   assign pc_o      = fifo_empty ? '0 : head.pc;
   assign fifo_push = accept && (!fifo_full || fifo_pop);
`endif
   assign fifo_pop  = valid_o && ready_i && !fifo_empty;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (redirect_i),
      .wdata (wentry),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (occ)
   );

   // The redirect-cycle request still fetches the stale stream, so discard
   // equals the post-edge in-flight count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight <= '0;
         discard  <= '0;
         wr_pc    <= '0;
      end else begin
         inflight <= inflight_next;
         if (redirect_i) begin
            discard <= inflight_next;
            wr_pc   <= redirect_addr_i;
         end else begin
            if ((discard != '0) && fetch_instr_valid_i) discard <= discard - CNT_W'(1);
            if (accept) wr_pc <= next_pc(wr_pc);
         end
      end
   end
endmodule

// File: tb/tb_prefetch_buffer.sv
// Directed table-driven bench for prefetch_buffer; the bench plays fetch_stage
// and decode. Bypass expectations follow PREFETCH_BYPASS_EN when defined.
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

module tb_prefetch_buffer;
   localparam int AW = `RISCV_ADDR_WIDTH;
   localparam int WW = `RISCV_WORD_WIDTH;

   typedef struct {
      logic          redir;
      logic [AW-1:0] raddr;
      logic          fv;
      logic [WW-1:0] finstr;
      logic          rdy;
      logic          e_req;
      logic          e_tv;
      logic          e_vld;
      logic [AW-1:0] e_pc;
      logic [WW-1:0] e_instr;
   } vec_t;

   logic          clk;
   logic          rst_n;
   logic          fetch_req;
   logic [AW-1:0] fetch_target_addr;
   logic          fetch_target_valid;
   logic [WW-1:0] fetch_instr;
   logic          fetch_instr_valid;
   logic          redirect;
   logic [AW-1:0] redirect_addr;
   logic [WW-1:0] instr;
   logic [AW-1:0] pc;
   logic          valid;
   logic          ready;

   int total = 0;
   int bad   = 0;
   int ovf_cnt = 0;
   vec_t tbl[$];
   vec_t byp[$];

   prefetch_buffer #(.DEPTH(4)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .fetch_req_o          (fetch_req),
      .fetch_target_addr_o  (fetch_target_addr),
      .fetch_target_valid_o (fetch_target_valid),
      .fetch_instr_i        (fetch_instr),
      .fetch_instr_valid_i  (fetch_instr_valid),
      .redirect_i           (redirect),
      .redirect_addr_i      (redirect_addr),
      .instr_o              (instr),
      .pc_o                 (pc),
      .valid_o              (valid),
      .ready_i              (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A response accepted into a full buffer without a pop would be an overflow.
   always @(posedge clk) begin
      if (rst_n && dut.accept && dut.fifo_full && !dut.fifo_pop) ovf_cnt <= ovf_cnt + 1;
   end

   function automatic vec_t mk(logic r, logic [AW-1:0] ra, logic fv, logic [WW-1:0] fi,
                               logic rd, logic er, logic et, logic ev,
                               logic [AW-1:0] ep, logic [WW-1:0] ei);
      vec_t v;
      v.redir = r;  v.raddr = ra; v.fv = fv; v.finstr = fi; v.rdy = rd;
      v.e_req = er; v.e_tv = et;  v.e_vld = ev; v.e_pc = ep; v.e_instr = ei;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, got, want);
      end
   endtask

   task automatic drive_idle();
      redirect = 1'b0; redirect_addr = '0; fetch_instr_valid = 1'b0;
      fetch_instr = '0; ready = 1'b0;
   endtask

   task automatic chk_zero(input int idx);
      chk("rst_fetch_req", idx, 32'(fetch_req), 32'd0);
      chk("rst_target_valid", idx, 32'(fetch_target_valid), 32'd0);
      chk("rst_valid", idx, 32'(valid), 32'd0);
      chk("rst_instr", idx, 32'(instr), 32'd0);
      chk("rst_pc", idx, 32'(pc), 32'd0);
   endtask

   // Entered just after a rising edge; outputs sampled mid-cycle.
   task automatic apply(input vec_t v, input int idx);
      redirect = v.redir; redirect_addr = v.raddr;
      fetch_instr_valid = v.fv; fetch_instr = v.finstr; ready = v.rdy;
      #3;
      chk("fetch_req", idx, 32'(fetch_req), 32'(v.e_req));
      chk("target_valid", idx, 32'(fetch_target_valid), 32'(v.e_tv));
      chk("valid", idx, 32'(valid), 32'(v.e_vld));
      chk("pc", idx, 32'(pc), 32'(v.e_pc));
      chk("instr", idx, 32'(instr), 32'(v.e_instr));
      if (v.e_tv) chk("target_addr", idx, 32'(fetch_target_addr), 32'(v.raddr));
      @(posedge clk); #1;
   endtask

   task automatic reset_pulse(input int idx);
      drive_idle();
      rst_n = 1'b0;
      #1;
      chk_zero(idx);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive_idle();

      // Steady stream from a cold redirect to 0x100
      tbl.push_back(mk(1, 'h100, 0, 0,          1, 1, 1, 0, 0,     0));
      tbl.push_back(mk(0, 0,     1, 'hDEAD0000, 1, 0, 0, 0, 0,     0));
      tbl.push_back(mk(0, 0,     0, 0,          1, 1, 0, 0, 0,     0));
      tbl.push_back(mk(0, 0,     1, 'hA0,       1, 1, 0, 0, 0,     0));
      tbl.push_back(mk(0, 0,     1, 'hA1,       1, 1, 0, 1, 'h100, 'hA0));
      tbl.push_back(mk(0, 0,     1, 'hA2,       1, 1, 0, 1, 'h101, 'hA1));
      tbl.push_back(mk(0, 0,     0, 0,          1, 1, 0, 1, 'h102, 'hA2));
      // Backpressure: four entries fill, requests stop, then drain in order
      tbl.push_back(mk(0, 0,     0, 0,          0, 1, 0, 0, 0,     0));
      tbl.push_back(mk(0, 0,     1, 'hB0,       0, 1, 0, 0, 0,     0));
      tbl.push_back(mk(0, 0,     1, 'hB1,       0, 0, 0, 1, 'h103, 'hB0));
      tbl.push_back(mk(0, 0,     1, 'hB2,       0, 0, 0, 1, 'h103, 'hB0));
      tbl.push_back(mk(0, 0,     1, 'hB3,       0, 0, 0, 1, 'h103, 'hB0));
      tbl.push_back(mk(0, 0,     0, 0,          0, 0, 0, 1, 'h103, 'hB0));
      tbl.push_back(mk(0, 0,     0, 0,          1, 0, 0, 1, 'h103, 'hB0));
      tbl.push_back(mk(0, 0,     0, 0,          1, 1, 0, 1, 'h104, 'hB1));
      tbl.push_back(mk(0, 0,     0, 0,          1, 1, 0, 1, 'h105, 'hB2));
      tbl.push_back(mk(0, 0,     0, 0,          1, 1, 0, 1, 'h106, 'hB3));
      tbl.push_back(mk(0, 0,     0, 0,          1, 1, 0, 0, 0,     0));
      tbl.push_back(mk(0, 0,     0, 0,          1, 0, 0, 0, 0,     0));
      // Two responses leave two in flight, then redirect to 0x200 (discard 3)
      tbl.push_back(mk(0, 0,     1, 'hC0,       0, 0, 0, 0, 0,     0));
      tbl.push_back(mk(0, 0,     1, 'hC1,       0, 0, 0, 1, 'h107, 'hC0));
      tbl.push_back(mk(1, 'h200, 0, 0,          0, 1, 1, 1, 'h107, 'hC0));
      tbl.push_back(mk(0, 0,     1, 'h5A1,      1, 0, 0, 0, 0,     0));
      tbl.push_back(mk(0, 0,     1, 'h5A2,      1, 0, 0, 0, 0,     0));
      tbl.push_back(mk(0, 0,     0, 0,          1, 0, 0, 0, 0,     0));
      tbl.push_back(mk(0, 0,     1, 'h5A3,      1, 0, 0, 0, 0,     0));
      tbl.push_back(mk(0, 0,     0, 0,          1, 1, 0, 0, 0,     0));
      tbl.push_back(mk(0, 0,     1, 'hD0,       1, 1, 0, 0, 0,     0));
      tbl.push_back(mk(0, 0,     0, 0,          1, 1, 0, 1, 'h200, 'hD0));
      // Redirect coincident with a response and a pop
      tbl.push_back(mk(0, 0,     1, 'hD1,       0, 1, 0, 0, 0,     0));
      tbl.push_back(mk(1, 'h300, 1, 'hBAD,      1, 1, 1, 1, 'h201, 'hD1));
      tbl.push_back(mk(0, 0,     0, 0,          1, 0, 0, 0, 0,     0));
      tbl.push_back(mk(0, 0,     1, 'h5B1,      1, 0, 0, 0, 0,     0));
      tbl.push_back(mk(0, 0,     1, 'h5B2,      1, 0, 0, 0, 0,     0));
      tbl.push_back(mk(0, 0,     0, 0,          1, 1, 0, 0, 0,     0));
      tbl.push_back(mk(0, 0,     1, 'hE0,       1, 1, 0, 0, 0,     0));
      tbl.push_back(mk(0, 0,     0, 0,          1, 1, 0, 1, 'h300, 'hE0));
      // Build up two buffered entries with one request in flight
      tbl.push_back(mk(0, 0,     1, 'hF0,       0, 1, 0, 0, 0,     0));
      tbl.push_back(mk(0, 0,     1, 'hF1,       0, 1, 0, 1, 'h301, 'hF0));
      tbl.push_back(mk(0, 0,     1, 'hF2,       1, 0, 0, 1, 'h301, 'hF0));

      // Response into an empty buffer with decode ready
      byp.push_back(mk(1, 'h100, 0, 0,      1, 1, 1, 0, 0, 0));
      byp.push_back(mk(0, 0,     1, 'h5C1,  1, 0, 0, 0, 0, 0));
      byp.push_back(mk(0, 0,     0, 0,      1, 1, 0, 0, 0, 0));
`ifdef PREFETCH_BYPASS_EN
      byp.push_back(mk(0, 0,     1, 'hB7,   1, 1, 0, 1, 'h100, 'hB7));
      byp.push_back(mk(0, 0,     0, 0,      1, 1, 0, 0, 0,     0));
`else
      byp.push_back(mk(0, 0,     1, 'hB7,   1, 1, 0, 0, 0,     0));
      byp.push_back(mk(0, 0,     0, 0,      1, 1, 0, 1, 'h100, 'hB7));
`endif

      #3;
      chk_zero(0);
      @(posedge clk); #1;
      rst_n = 1'b1;

`ifndef PREFETCH_BYPASS_EN
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

      // Buffer holds F1,F2 with one request outstanding; reset mid-operation
      drive_idle();
      #1;
      chk("pre_reset_valid", 0, 32'(valid), 32'd1);
      chk("pre_reset_pc", 0, 32'(pc), 32'h302);
      reset_pulse(1);
      for (int i = 0; i < 7; i++) apply(tbl[i], 100 + i);
      reset_pulse(2);
`endif
      for (int i = 0; i < byp.size(); i++) apply(byp[i], 200 + i);

      chk("no_overflow", 0, 32'(ovf_cnt), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
